// File: rtl/stash_read_checker.sv
// stash_read_checker
// Passive checker for the stash read (path-writeback) port. It holds a FIFO of
// expected-block descriptors, compares each beat against the descriptor at the
// head of the FIFO and reports errors through sticky registers.
//
// Error codes:
//   1 data mismatch, 2 PAddr/leaf mismatch, 3 block size, 4 dummy block with a
//   real PAddr, 5 dummy PAddr inside a real descriptor, 6 beat with no descriptor.
//
// Build option: define STASH_CHECKER_SKIP_DUMMY_EN so that whole dummy-address
// blocks seen while a real descriptor is at the head are skipped rather than
// flagged. This also adds the SkippedCount output.
//
// Handshake semantics:
//   Descriptor side: a descriptor is accepted on a cycle with ExpValid & ExpReady.
//   ExpReady depends only on registered FIFO occupancy. It stays low while the
//   FIFO is full, even in a cycle where an entry retires.
//   Read side (monitored only): a beat is ReadOutValid & ReadOutReady.
//   BlockReadComplete qualifies the last beat of a block.
module stash_read_checker #(
    parameter int DataWidth                     = 512,
    parameter int ORAMU                         = 32,
    parameter int ORAML                         = 32,
    parameter int NumChunks                     = 8,
    parameter logic [ORAMU-1:0] DummyBlockAddress = {ORAMU{1'b1}},
    parameter int QueueDepth                    = 16,
    parameter int CountWidth                    = 16,
    parameter int ErrCountWidth                 = 16
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [DataWidth-1:0]     ExpData,
    input  logic [ORAMU-1:0]         ExpPAddr,
    input  logic [ORAML-1:0]         ExpLeaf,
    input  logic                     ExpIsDummy,
    input  logic [CountWidth-1:0]    ExpCount,
    input  logic                     ExpValid,
    output logic                     ExpReady,
    input  logic [DataWidth-1:0]     ReadData,
    input  logic [ORAMU-1:0]         ReadPAddr,
    input  logic [ORAML-1:0]         ReadLeaf,
    input  logic                     ReadOutValid,
    input  logic                     ReadOutReady,
    input  logic                     BlockReadComplete,
    output logic                     DescDone,
    output logic                     Busy,
    output logic                     ErrorFlag,
    output logic [2:0]               ErrorCode,
    output logic [ErrCountWidth-1:0] ErrorCount,
    output logic [31:0]              BlocksChecked,
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
    output logic [31:0]              SkippedCount,
`endif
    output logic [1:0]               DebugState
);

    localparam int AddrWidth  = $clog2(QueueDepth);
    localparam int ChunkWidth = $clog2(NumChunks) + 1;
    localparam logic [ChunkWidth-1:0] LastChunk = ChunkWidth'(NumChunks - 1);
    localparam logic [ChunkWidth-1:0] ChunkMax  = {ChunkWidth{1'b1}};
    localparam logic [AddrWidth:0]    FullLevel = (AddrWidth + 1)'(QueueDepth);
    localparam logic [ErrCountWidth-1:0] ErrCountMax = {ErrCountWidth{1'b1}};

    localparam logic [2:0] ErrData       = 3'd1;
    localparam logic [2:0] ErrAddrLeaf   = 3'd2;
    localparam logic [2:0] ErrSize       = 3'd3;
    localparam logic [2:0] ErrDummyAddr  = 3'd4;
    localparam logic [2:0] ErrRealDummy  = 3'd5;
    localparam logic [2:0] ErrUnexpected = 3'd6;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReal  = 2'd1,
        StDummy = 2'd2
    } stateT;

    // Descriptor storage. No reset is needed: occupancy qualifies every entry.
    logic [DataWidth-1:0]  memData    [QueueDepth];
    logic [ORAMU-1:0]      memPAddr   [QueueDepth];
    logic [ORAML-1:0]      memLeaf    [QueueDepth];
    logic                  memIsDummy [QueueDepth];
    logic [CountWidth-1:0] memCount   [QueueDepth];

    logic [AddrWidth-1:0]  rdPtr;
    logic [AddrWidth-1:0]  wrPtr;
    logic [AddrWidth:0]    occupancy;

    stateT                 state;
    logic [CountWidth-1:0] runCount;
    logic [ChunkWidth-1:0] chunkCnt;
    logic                  blockErrSeen;

    logic                     descDoneReg;
    logic                     errorFlagReg;
    logic [2:0]               errorCodeReg;
    logic [ErrCountWidth-1:0] errorCountReg;
    logic [31:0]              blocksCheckedReg;
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
    logic [31:0]              skippedCountReg;
`endif

    // Head descriptor fields, combinational reads of the registered FIFO.
    logic [DataWidth-1:0] headData;
    logic [ORAMU-1:0]     headPAddr;
    logic [ORAML-1:0]     headLeaf;
    logic [DataWidth-1:0] expWord;

    logic       push;
    logic       pop;
    logic       beat;
    logic       blockEnd;
    logic       atLastChunk;
    logic       sizeErr;
    logic       readIsDummyAddr;
    logic       zeroRun;
    logic       skipBeat;
    logic       realRetire;
    logic       dummyBlock;
    logic       retire;
    logic       blockCounted;
    logic [2:0] beatCode;

    logic [AddrWidth:0]    remaining;
    logic [AddrWidth-1:0]  nextRdPtr;
    logic                  nextHeadValid;
    logic                  nextHeadIsDummy;
    logic [CountWidth-1:0] nextHeadCount;
    logic                  headChange;

    assign headData  = memData[rdPtr];
    assign headPAddr = memPAddr[rdPtr];
    assign headLeaf  = memLeaf[rdPtr];
    assign expWord   = headData + DataWidth'(chunkCnt);

    assign ExpReady = (occupancy != FullLevel);
    assign push     = ExpValid & ExpReady;

    assign beat            = ReadOutValid & ReadOutReady;
    assign blockEnd        = beat & BlockReadComplete;
    assign atLastChunk     = (chunkCnt == LastChunk);
    assign sizeErr         = BlockReadComplete ? !atLastChunk : atLastChunk;
    assign readIsDummyAddr = (ReadPAddr == DummyBlockAddress);

    // A zero-length dummy run retires on its first cycle at the head and consumes no beats.
    assign zeroRun = (state == StDummy) && (runCount == '0);

`ifdef STASH_CHECKER_SKIP_DUMMY_EN
    assign skipBeat = (state == StReal) && readIsDummyAddr;
`else
    assign skipBeat = 1'b0;
`endif

    assign realRetire   = (state == StReal) && blockEnd && !skipBeat;
    assign dummyBlock   = (state == StDummy) && !zeroRun && blockEnd;
    assign retire       = realRetire || (dummyBlock && (runCount == CountWidth'(1))) || zeroRun;
    assign blockCounted = realRetire || dummyBlock;
    assign pop          = retire;

    // Classify the current beat. Checks are ordered so the first match has the highest priority.
    always_comb begin
        beatCode = 3'd0;
        if (beat) begin
            if ((state == StIdle) || zeroRun) begin
                beatCode = ErrUnexpected;
            end else if (sizeErr) begin
                beatCode = ErrSize;
            end else if (state == StDummy) begin
                if (BlockReadComplete && !readIsDummyAddr) begin
                    beatCode = ErrDummyAddr;
                end
            end else if (!skipBeat) begin
                if (readIsDummyAddr) begin
                    beatCode = ErrRealDummy;
                end else if (BlockReadComplete &&
                             ((ReadPAddr != headPAddr) || (ReadLeaf != headLeaf))) begin
                    beatCode = ErrAddrLeaf;
                end else if (ReadData != expWord) begin
                    beatCode = ErrData;
                end
            end
        end
    end

    // Work out which descriptor is at the head after this cycle's push/pop,
    // so that the FSM state always matches the head of the FIFO.
    always_comb begin
        remaining       = occupancy - (AddrWidth + 1)'(pop);
        nextRdPtr       = rdPtr + AddrWidth'(pop);
        nextHeadValid   = 1'b0;
        nextHeadIsDummy = 1'b0;
        nextHeadCount   = '0;
        if (remaining != '0) begin
            nextHeadValid   = 1'b1;
            nextHeadIsDummy = memIsDummy[nextRdPtr];
            nextHeadCount   = memCount[nextRdPtr];
        end else if (push) begin
            nextHeadValid   = 1'b1;
            nextHeadIsDummy = ExpIsDummy;
            nextHeadCount   = ExpCount;
        end
    end

    assign headChange = pop || ((occupancy == '0) && push);

    // Write accepted descriptors into the FIFO storage.
    always_ff @(posedge Clock) begin
        if (push) begin
            memData[wrPtr]    <= ExpData;
            memPAddr[wrPtr]   <= ExpPAddr;
            memLeaf[wrPtr]    <= ExpLeaf;
            memIsDummy[wrPtr] <= ExpIsDummy;
            memCount[wrPtr]   <= ExpCount;
        end
    end

    // Checker FSM: FIFO pointers, head mode, chunk/run counters and the registered results.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rdPtr            <= '0;
            wrPtr            <= '0;
            occupancy        <= '0;
            state            <= StIdle;
            runCount         <= '0;
            chunkCnt         <= '0;
            blockErrSeen     <= 1'b0;
            descDoneReg      <= 1'b0;
            errorFlagReg     <= 1'b0;
            errorCodeReg     <= 3'd0;
            errorCountReg    <= '0;
            blocksCheckedReg <= '0;
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
            skippedCountReg  <= '0;
`endif
        end else begin
            occupancy <= occupancy + (AddrWidth + 1)'(push) - (AddrWidth + 1)'(pop);
            if (push) begin
                wrPtr <= wrPtr + AddrWidth'(1);
            end
            if (pop) begin
                rdPtr <= nextRdPtr;
            end

            if (headChange) begin
                if (!nextHeadValid) begin
                    state <= StIdle;
                end else if (nextHeadIsDummy) begin
                    state <= StDummy;
                end else begin
                    state <= StReal;
                end
                runCount <= nextHeadCount;
            end else if (dummyBlock) begin
                runCount <= runCount - CountWidth'(1);
            end

            // The chunk counter follows the monitored stream in every state.
            if (beat) begin
                if (BlockReadComplete) begin
                    chunkCnt <= '0;
                end else if (chunkCnt != ChunkMax) begin
                    chunkCnt <= chunkCnt + ChunkWidth'(1);
                end
            end

            if (beatCode != 3'd0) begin
                if (!errorFlagReg) begin
                    errorFlagReg <= 1'b1;
                    errorCodeReg <= beatCode;
                end
                if (!blockErrSeen && (errorCountReg != ErrCountMax)) begin
                    errorCountReg <= errorCountReg + ErrCountWidth'(1);
                end
            end

            if (blockEnd) begin
                blockErrSeen <= 1'b0;
            end else if (beatCode != 3'd0) begin
                blockErrSeen <= 1'b1;
            end

            descDoneReg <= retire;
            if (blockCounted) begin
                blocksCheckedReg <= blocksCheckedReg + 32'd1;
            end
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
            if (skipBeat && blockEnd) begin
                skippedCountReg <= skippedCountReg + 32'd1;
            end
`endif
        end
    end

    assign DescDone      = descDoneReg;
    assign Busy          = (occupancy != '0);
    assign ErrorFlag     = errorFlagReg;
    assign ErrorCode     = errorCodeReg;
    assign ErrorCount    = errorCountReg;
    assign BlocksChecked = blocksCheckedReg;
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
    assign SkippedCount  = skippedCountReg;
`endif
    assign DebugState    = state;

endmodule

// File: tb/tb_stash_read_checker.sv
// Bench for stash_read_checker: directed scenarios followed by a randomized run,
// checked against a transaction-level model built on a descriptor queue.
module tb_stash_read_checker;

    localparam int DW = 512;
    localparam int N  = 8;
    localparam int QD = 16;
    localparam logic [31:0] DUMMY_ADDR = 32'hffff_ffff;
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    logic          Clock = 1'b0;
    logic          Reset;
    logic [DW-1:0] ExpData;
    logic [31:0]   ExpPAddr;
    logic [31:0]   ExpLeaf;
    logic          ExpIsDummy;
    logic [15:0]   ExpCount;
    logic          ExpValid;
    logic          ExpReady;
    logic [DW-1:0] ReadData;
    logic [31:0]   ReadPAddr;
    logic [31:0]   ReadLeaf;
    logic          ReadOutValid;
    logic          ReadOutReady;
    logic          BlockReadComplete;
    logic          DescDone;
    logic          Busy;
    logic          ErrorFlag;
    logic [2:0]    ErrorCode;
    logic [15:0]   ErrorCount;
    logic [31:0]   BlocksChecked;
    logic [1:0]    DebugState;
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
    logic [31:0]   SkippedCount;
`endif

    stash_read_checker dut (
        .Clock(Clock), .Reset(Reset),
        .ExpData(ExpData), .ExpPAddr(ExpPAddr), .ExpLeaf(ExpLeaf),
        .ExpIsDummy(ExpIsDummy), .ExpCount(ExpCount), .ExpValid(ExpValid),
        .ExpReady(ExpReady),
        .ReadData(ReadData), .ReadPAddr(ReadPAddr), .ReadLeaf(ReadLeaf),
        .ReadOutValid(ReadOutValid), .ReadOutReady(ReadOutReady),
        .BlockReadComplete(BlockReadComplete),
        .DescDone(DescDone), .Busy(Busy), .ErrorFlag(ErrorFlag),
        .ErrorCode(ErrorCode), .ErrorCount(ErrorCount),
        .BlocksChecked(BlocksChecked),
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
        .SkippedCount(SkippedCount),
`endif
        .DebugState(DebugState)
    );

    // Clock and watchdog
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard state
    typedef struct {
        logic [DW-1:0] data;
        logic [31:0]   pa;
        logic [31:0]   lf;
        bit            dummy;
        int            cnt;
    } descT;

    descT expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   k;
    bit   blkErr;
    bit   mFlag;
    int   mCode;
    int   mCount;
    int   mBlocks;
    int   mDone;
    int   mSkipped;
    int   doneSeen = 0;

    always @(negedge Clock) begin
        if (DescDone === 1'b1) doneSeen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        if ($urandom_range(0, 7) == 0) r = {DW{1'b1}} - DW'($urandom_range(0, 4));
        return r;
    endfunction

    function automatic descT makeReal();
        descT d;
        d.data = randData();
        d.pa = $urandom >> 1;
        d.lf = $urandom;
        d.dummy = 1'b0;
        d.cnt = 0;
        return d;
    endfunction

    function automatic descT makeDummy(input int cnt);
        descT d;
        d.data = '0;
        d.pa = DUMMY_ADDR;
        d.lf = '0;
        d.dummy = 1'b1;
        d.cnt = cnt;
        return d;
    endfunction

    // Reference model: one monitored beat applied to the descriptor queue.
    task automatic modelBeat(input logic [DW-1:0] data, input logic [31:0] pa,
                             input logic [31:0] lf, input bit brc);
        int   code;
        bit   skip;
        bit   sizeBad;
        descT h;
        code = 0;
        skip = 1'b0;
        sizeBad = brc ? (k != N - 1) : (k == N - 1);
        if (expQ.size() == 0) begin
            code = 6;
        end else begin
            h = expQ[0];
            if (h.dummy) begin
                if (sizeBad) code = 3;
                else if (brc && pa != DUMMY_ADDR) code = 4;
            end else begin
                skip = SKIP_EN && (pa == DUMMY_ADDR);
                if (sizeBad) code = 3;
                else if (!skip) begin
                    if (pa == DUMMY_ADDR) code = 5;
                    else if (brc && (pa != h.pa || lf != h.lf)) code = 2;
                    else if (data != h.data + DW'(k)) code = 1;
                end
            end
        end
        if (code != 0) begin
            if (!mFlag) begin
                mFlag = 1'b1;
                mCode = code;
            end
            if (!blkErr) begin
                blkErr = 1'b1;
                if (mCount < 65535) mCount++;
            end
        end
        if (brc && expQ.size() != 0) begin
            h = expQ[0];
            if (h.dummy) begin
                mBlocks++;
                h.cnt--;
                expQ[0] = h;
                if (h.cnt == 0) begin
                    void'(expQ.pop_front());
                    mDone++;
                end
            end else if (skip) begin
                mSkipped++;
            end else begin
                mBlocks++;
                void'(expQ.pop_front());
                mDone++;
            end
        end
        if (brc) begin
            k = 0;
            blkErr = 1'b0;
        end else begin
            k++;
        end
    endtask

    // Driver tasks: all start and end at a falling edge.
    task automatic idle(input int n);
        ReadOutValid = 1'b0;
        ReadOutReady = 1'b0;
        BlockReadComplete = 1'b0;
        ExpValid = 1'b0;
        repeat (n) @(negedge Clock);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        idle(2);
        expQ.delete();
        k = 0; blkErr = 0; mFlag = 0; mCode = 0; mCount = 0;
        mBlocks = 0; mDone = 0; mSkipped = 0; doneSeen = 0;
        Reset = 1'b0;
        @(negedge Clock);
    endtask

    task automatic enq(input descT d);
        int w;
        w = 0;
        while (ExpReady !== 1'b1 && w < 100) begin
            @(negedge Clock);
            w++;
        end
        if (ExpReady !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL enq_wait observed=ExpReady_low required=ExpReady_high");
        end
        ExpData = d.data;
        ExpPAddr = d.pa;
        ExpLeaf = d.lf;
        ExpIsDummy = d.dummy;
        ExpCount = 16'(d.cnt);
        ExpValid = 1'b1;
        @(negedge Clock);
        ExpValid = 1'b0;
        if (d.dummy && d.cnt == 0 && expQ.size() == 0) mDone++;
        else expQ.push_back(d);
    endtask

    task automatic driveBeat(input logic [DW-1:0] data, input logic [31:0] pa,
                             input logic [31:0] lf, input bit brc, input bit allowStall);
        if (allowStall && $urandom_range(0, 3) == 0) begin
            ReadOutValid = 1'($urandom_range(0, 1));
            ReadOutReady = ReadOutValid ? 1'b0 : 1'($urandom_range(0, 1));
            ReadData = randData();
            ReadPAddr = $urandom;
            BlockReadComplete = 1'($urandom_range(0, 1));
            @(negedge Clock);
        end
        ReadOutValid = 1'b1;
        ReadOutReady = 1'b1;
        ReadData = data;
        ReadPAddr = pa;
        ReadLeaf = lf;
        BlockReadComplete = brc;
        @(negedge Clock);
        modelBeat(data, pa, lf, brc);
        ReadOutValid = 1'b0;
        ReadOutReady = 1'b0;
        BlockReadComplete = 1'b0;
    endtask

    // mode: 0-4 clean, 5 data, 6 PAddr, 7 leaf, 8 size, 9 dummy-address block
    task automatic sendBlock(input descT d, input int mode, input bit stall);
        int            len;
        int            bad;
        logic [DW-1:0] data;
        logic [31:0]   pa;
        logic [31:0]   lf;
        bit            brc;
        len = N;
        if (mode == 8) len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, N - 1) : N + $urandom_range(1, 2);
        bad = $urandom_range(0, len - 1);
        for (int i = 0; i < len; i++) begin
            brc = (i == len - 1);
            if (d.dummy) begin
                data = randData();
                pa = DUMMY_ADDR;
                lf = $urandom;
                if ((mode == 6 || mode == 7) && brc) pa = $urandom >> 1;
            end else begin
                data = d.data + DW'(i);
                pa = d.pa;
                lf = d.lf;
                if (mode == 5 && i == bad) data = data + DW'(1);
                if (mode == 6 && brc) pa = pa ^ 32'd1;
                if (mode == 7 && brc) lf = lf ^ 32'd1;
                if (mode == 9) pa = DUMMY_ADDR;
            end
            driveBeat(data, pa, lf, brc, stall);
        end
    endtask

    task automatic checkAll(input string tag);
        idle(2);
        chk({tag, "_flag"}, 64'(ErrorFlag), 64'(mFlag));
        chk({tag, "_code"}, 64'(ErrorCode), 64'(mCode));
        chk({tag, "_count"}, 64'(ErrorCount), 64'(mCount));
        chk({tag, "_blocks"}, 64'(BlocksChecked), 64'(mBlocks));
        chk({tag, "_done"}, 64'(doneSeen), 64'(mDone));
        chk({tag, "_busy"}, 64'(Busy), 64'(expQ.size() != 0));
        chk({tag, "_ready"}, 64'(ExpReady), 64'(expQ.size() < QD));
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
        chk({tag, "_skipped"}, 64'(SkippedCount), 64'(mSkipped));
`endif
    endtask

    initial begin
        descT d;
        descT d2;
        int   nb;
        int   guard;

        Reset = 1'b1;
        ExpData = '0; ExpPAddr = '0; ExpLeaf = '0; ExpIsDummy = 1'b0; ExpCount = '0;
        ExpValid = 1'b0;
        ReadData = '0; ReadPAddr = '0; ReadLeaf = '0;
        ReadOutValid = 1'b0; ReadOutReady = 1'b0; BlockReadComplete = 1'b0;
        @(negedge Clock);
        doReset();

        chk("rst_ready", 64'(ExpReady), 64'd1);
        chk("rst_busy", 64'(Busy), 64'd0);
        chk("rst_flag", 64'(ErrorFlag), 64'd0);
        chk("rst_blocks", 64'(BlocksChecked), 64'd0);

        // Scenario 1: dummy run of 3 then a real block with base 16
        enq(makeDummy(3));
        d.data = DW'(16); d.pa = 32'hf000_0002; d.lf = 32'h0000_ffff; d.dummy = 1'b0; d.cnt = 0;
        enq(d);
        idle(1);
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < N; i++) driveBeat(randData(), DUMMY_ADDR, $urandom, i == N - 1, 1'b0);
        for (int i = 0; i < N; i++) driveBeat(DW'(16 + i), 32'hf000_0002, 32'h0000_ffff, i == N - 1, 1'b0);
        checkAll("t1");
        chk("t1_done_const", 64'(doneSeen), 64'd2);
        chk("t1_blocks_const", 64'(BlocksChecked), 64'd4);

        // Scenario 2: bad data from chunk 3, then a clean descriptor
        doReset();
        d = makeReal(); d.data = '0;
        d2 = makeReal();
        enq(d);
        enq(d2);
        for (int i = 0; i < 3; i++) driveBeat(DW'(i), d.pa, d.lf, 1'b0, 1'b0);
        chk("t2_flag_before", 64'(ErrorFlag), 64'd0);
        driveBeat(DW'(99), d.pa, d.lf, 1'b0, 1'b0);
        chk("t2_flag_after", 64'(ErrorFlag), 64'd1);
        chk("t2_code", 64'(ErrorCode), 64'd1);
        for (int i = 4; i < N; i++) driveBeat(DW'(99 + i), d.pa, d.lf, i == N - 1, 1'b0);
        checkAll("t2a");
        sendBlock(d2, 0, 1'b1);
        checkAll("t2b");
        chk("t2_count_const", 64'(ErrorCount), 64'd1);

        // Scenario 3: block ends at chunk 5
        doReset();
        d = makeReal();
        d2 = makeReal();
        enq(d);
        enq(d2);
        for (int i = 0; i < 6; i++) driveBeat(d.data + DW'(i), d.pa, d.lf, i == 5, 1'b0);
        checkAll("t3a");
        chk("t3_code_const", 64'(ErrorCode), 64'd3);
        sendBlock(d2, 0, 1'b0);
        checkAll("t3b");

        // Scenario 4: beats with no descriptor queued
        doReset();
        driveBeat(randData(), $urandom, $urandom, 1'b0, 1'b0);
        idle(1);
        chk("t4_code", 64'(ErrorCode), 64'd6);
        chk("t4_ready", 64'(ExpReady), 64'd1);
        chk("t4_busy", 64'(Busy), 64'd0);
        for (int i = 1; i < N; i++) driveBeat(randData(), $urandom, $urandom, i == N - 1, 1'b0);
        checkAll("t4");

        // Zero-length dummy run retires without beats
        doReset();
        enq(makeDummy(0));
        checkAll("zero");
        chk("zero_done_const", 64'(doneSeen), 64'd1);

        // Scenario 5: fill the queue, then retire while a new descriptor is offered
        doReset();
        for (int i = 0; i < QD; i++) enq(makeReal());
        idle(1);
        chk("t5_full_ready", 64'(ExpReady), 64'd0);
        chk("t5_full_busy", 64'(Busy), 64'd1);
        d = expQ[0];
        for (int i = 0; i < N - 1; i++) driveBeat(d.data + DW'(i), d.pa, d.lf, 1'b0, 1'b0);
        d2 = makeReal();
        ExpData = d2.data; ExpPAddr = d2.pa; ExpLeaf = d2.lf; ExpIsDummy = 1'b0; ExpCount = '0;
        ExpValid = 1'b1;
        driveBeat(d.data + DW'(N - 1), d.pa, d.lf, 1'b1, 1'b0);
        chk("t5_ready_after_retire", 64'(ExpReady), 64'd1);
        @(negedge Clock);
        ExpValid = 1'b0;
        expQ.push_back(d2);
        chk("t5_ready_refull", 64'(ExpReady), 64'd0);
        while (expQ.size() != 0) sendBlock(expQ[0], 0, 1'b1);
        checkAll("t5");
        chk("t5_done_const", 64'(doneSeen), 64'd17);

        // Scenario 6: reset in the middle of a block, then a clean block
        doReset();
        d = makeReal();
        enq(d);
        for (int i = 0; i < 4; i++) driveBeat(d.data + DW'(i), d.pa, d.lf, 1'b0, 1'b0);
        doReset();
        chk("t6_rst_flag", 64'(ErrorFlag), 64'd0);
        chk("t6_rst_code", 64'(ErrorCode), 64'd0);
        chk("t6_rst_count", 64'(ErrorCount), 64'd0);
        chk("t6_rst_blocks", 64'(BlocksChecked), 64'd0);
        chk("t6_rst_done", 64'(DescDone), 64'd0);
        chk("t6_rst_busy", 64'(Busy), 64'd0);
        chk("t6_rst_ready", 64'(ExpReady), 64'd1);
        d = makeReal();
        enq(d);
        sendBlock(d, 0, 1'b0);
        checkAll("t6");

        // Dummy-address block inside a real descriptor
        doReset();
        d = makeReal();
        enq(d);
        sendBlock(d, 9, 1'b0);
        while (expQ.size() != 0) sendBlock(expQ[0], 0, 1'b0);
        checkAll("skip");
`ifdef STASH_CHECKER_SKIP_DUMMY_EN
        chk("skip_count_const", 64'(SkippedCount), 64'd1);
        chk("skip_flag_const", 64'(ErrorFlag), 64'd0);
`else
        chk("skip_code_const", 64'(ErrorCode), 64'd5);
`endif

        // Randomized run against the model
        doReset();
        for (int it = 0; it < 30; it++) begin
            nb = $urandom_range(1, 4);
            for (int j = 0; j < nb; j++) begin
                if ($urandom_range(0, 2) == 0) enq(makeDummy($urandom_range(1, 3)));
                else enq(makeReal());
            end
            guard = 0;
            while (expQ.size() != 0 && guard < 100) begin
                sendBlock(expQ[0], $urandom_range(0, 9), 1'b1);
                guard++;
            end
            checkAll("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
